// File: rtl/rc4_keystream_if.sv
// ---------------------------------------------------------------------------
// rc4_keystream_if
//   Control/stream bundle between an RC4 keystream generator and its user.
//
//   Parameters
//     KEY_LEN   key length in bytes (1..16)
//
//   Signals
//     start     single-cycle rekey request (user -> generator)
//     key       key bytes, byte 0 in the top 8 bits (user -> generator)
//     busy      generator is scheduling the key (generator -> user)
//     ks_valid  ks_data holds a keystream byte (generator -> user)
//     ks_ready  user accepts the byte on a valid&&ready edge (user -> generator)
//     ks_data   keystream byte (generator -> user)
//
//   Modports
//     master    generator side
//     slave     user side
// ---------------------------------------------------------------------------
interface rc4_keystream_if #(
    parameter int KEY_LEN = 3
) ();
    logic                 start;
    logic [8*KEY_LEN-1:0] key;
    logic                 busy;
    logic                 ks_valid;
    logic                 ks_ready;
    logic [7:0]           ks_data;

    modport master (
        input  start,
        input  key,
        input  ks_ready,
        output busy,
        output ks_valid,
        output ks_data
    );

    modport slave (
        output start,
        output key,
        output ks_ready,
        input  busy,
        input  ks_valid,
        input  ks_data
    );
endinterface

// File: rtl/rc4_keystream_gen.sv
// ---------------------------------------------------------------------------
// rc4_keystream_gen
//   RC4 keystream source. On start the key is latched, the S-box is
//   initialised (256 cycles) and key-scheduled (256 cycles); keystream bytes
//   are then produced one per STEP and offered on a valid/ready handshake.
//
//   Parameters
//     KEY_LEN     key length in bytes (1..16)
//     DROP_COUNT  keystream bytes discarded after KSA (>= 1); exists only
//                 when RC4_DROP_EN is defined
//
//   Ports
//     clk         system clock, rising edge
//     rst         asynchronous, active-high reset
//     bus         rc4_keystream_if.master: start, key, busy, ks_valid,
//                 ks_ready, ks_data
//
//   Build option
//     RC4_DROP_EN  inserts DROP between KSA and the first STEP (RC4-dropN)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start
//   INIT  | S[i] = i, one entry per cycle
//   KSA   | key scheduling swap, one per cycle
//   DROP  | PRGA iterations with output discarded (RC4_DROP_EN only)
//   STEP  | one PRGA iteration, keystream byte registered
//   OUT   | ks_valid high, waiting for ks_ready
// ---------------------------------------------------------------------------
module rc4_keystream_gen #(
    parameter int KEY_LEN = 3
`ifdef RC4_DROP_EN
    , parameter int DROP_COUNT = 256
`endif
) (
    input  logic           clk,
    input  logic           rst,
    rc4_keystream_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
`ifdef RC4_DROP_EN
        DROP,
`endif
        STEP,
        OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]           s_mem [256];
    logic [7:0]           i_q;
    logic [7:0]           j_q;
    logic [8*KEY_LEN-1:0] key_q;
    logic [7:0]           ks_data_q;

    logic load_key;
    logic do_init;
    logic do_ksa;
    logic do_prga;
    logic load_ks;

    logic [7:0] key_byte;
    logic [7:0] idx_a;
    logic [7:0] val_a;
    logic [7:0] j_new;
    logic [7:0] val_b;
    logic [7:0] ks_idx;
    logic [7:0] ks_byte;

    // -----------------------------------------------------------------------
    // Swap datapath shared by KSA and PRGA. KSA swaps at i and adds the key
    // byte; PRGA swaps at i+1 and adds nothing.
    // -----------------------------------------------------------------------
    // The key register rotates one byte per KSA cycle, so the active key byte
    // is always the top one and the index wraps modulo KEY_LEN for free.
    assign key_byte = key_q[8*KEY_LEN-1 -: 8];
    assign idx_a    = (state_q == KSA) ? i_q : i_q + 8'd1;
    assign val_a    = s_mem[idx_a];
    assign j_new    = j_q + val_a + ((state_q == KSA) ? key_byte : 8'd0);
    assign val_b    = s_mem[j_new];
    assign ks_idx   = val_a + val_b;

    // The output byte must be read from the post-swap S. The sum is the same
    // before and after the swap; only a hit on one of the two swapped entries
    // needs the exchanged value.
    always_comb begin
        ks_byte = s_mem[ks_idx];
        if (ks_idx == j_new) begin
            ks_byte = val_a;
        end else if (ks_idx == idx_a) begin
            ks_byte = val_b;
        end
    end

`ifdef RC4_DROP_EN
    localparam int DCW = (DROP_COUNT > 1) ? $clog2(DROP_COUNT) : 1;

    logic [DCW-1:0] drop_cnt_q;
    logic           drop_done;

    assign drop_done = (drop_cnt_q == '0);

    // Down-counter armed during KSA; DROP leaves on terminal count, giving
    // exactly DROP_COUNT discarded iterations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (state_q == KSA) begin
            drop_cnt_q <= DCW'(DROP_COUNT - 1);
        end else if ((state_q == DROP) && !drop_done) begin
            drop_cnt_q <= drop_cnt_q - 1'b1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_key = 1'b0;
        do_init  = 1'b0;
        do_ksa   = 1'b0;
        do_prga  = 1'b0;
        load_ks  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_key = 1'b1;
                    state_d  = INIT;
                end
            end
            INIT: begin
                do_init = 1'b1;
                if (i_q == 8'hFF) begin
                    state_d = KSA;
                end
            end
            KSA: begin
                do_ksa = 1'b1;
                if (i_q == 8'hFF) begin
`ifdef RC4_DROP_EN
                    state_d = DROP;
`else
                    state_d = STEP;
`endif
                end
            end
`ifdef RC4_DROP_EN
            DROP: begin
                do_prga = 1'b1;
                if (drop_done) begin
                    state_d = STEP;
                end
            end
`endif
            STEP: begin
                if (bus.start) begin
                    load_key = 1'b1;
                    state_d  = INIT;
                end else begin
                    do_prga = 1'b1;
                    load_ks = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                // A rekey request beats a same-cycle handshake; that byte is
                // treated as never delivered.
                if (bus.start) begin
                    load_key = 1'b1;
                    state_d  = INIT;
                end else if (bus.ks_ready) begin
                    state_d = STEP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Indices, key and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            key_q     <= '0;
            ks_data_q <= 8'd0;
        end else begin
            if (load_key) begin
                key_q <= bus.key;
                i_q   <= 8'd0;
                j_q   <= 8'd0;
            end else if (do_init) begin
                i_q <= i_q + 8'd1;
                j_q <= 8'd0;
            end else if (do_ksa) begin
                i_q   <= i_q + 8'd1;
                j_q   <= (i_q == 8'hFF) ? 8'd0 : j_new;
                key_q <= (key_q << 8) | (key_q >> (8*KEY_LEN - 8));
            end else if (do_prga) begin
                i_q <= idx_a;
                j_q <= j_new;
            end
            if (load_ks) begin
                ks_data_q <= ks_byte;
            end
        end
    end

    // S is fully rewritten by INIT before any read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_init) begin
            s_mem[i_q] <= i_q;
        end else if (do_ksa || do_prga) begin
            s_mem[idx_a] <= val_b;
            s_mem[j_new] <= val_a;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.ks_valid = (state_q == OUT);
    assign bus.ks_data  = ks_data_q;
`ifdef RC4_DROP_EN
    assign bus.busy     = (state_q == INIT) || (state_q == KSA) || (state_q == DROP);
`else
    assign bus.busy     = (state_q == INIT) || (state_q == KSA);
`endif

endmodule
